// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared types and constants for the MIPS front end. Holds the fetch FSM
//   state type, the bubble instruction word and the opcode field values that
//   main_decoder decodes from instr_d[31:26].
//   No ports (package).
// ---------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory request/response channel between the fetch stage
//   (master) and instruction memory (slave).
//   req_valid  master->slave  request valid
//   req_addr   master->slave  byte address of the requested word
//   req_ready  slave->master  request accepted this cycle
//   rsp_valid  slave->master  response word valid
//   rsp_data   slave->master  instruction word
// ---------------------------------------------------------------------------
interface fetch_stage_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register. Priority: reset, flush (bubble), stall (hold),
//   load (new word), otherwise bubble.
//   clk, rst_n       clock, synchronous active-low reset
//   flush            force a bubble, overrides stall
//   stall            keep current contents
//   load             capture instr_in / pc_plus4_in as a valid instruction
//   instr_d          registered instruction (NOP when invalid)
//   pc_plus4_d       registered pc+4 of instr_d
//   valid_d          register holds a real instruction
// ---------------------------------------------------------------------------
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  logic [31:0] ir_instr_q, ir_instr_d;
  logic [31:0] ir_pc4_q, ir_pc4_d;
  logic        ir_valid_q, ir_valid_d;

  always_comb begin
    ir_instr_d = ir_instr_q;
    ir_pc4_d   = ir_pc4_q;
    ir_valid_d = ir_valid_q;
    if (flush) begin
      ir_instr_d = NOP_INSTR;
      ir_valid_d = 1'b0;
    end else if (!stall) begin
      if (load) begin
        ir_instr_d = instr_in;
        ir_pc4_d   = pc_plus4_in;
        ir_valid_d = 1'b1;
      end else begin
        // pc_plus4_d keeps its last value under a bubble; only valid/instr matter
        ir_instr_d = NOP_INSTR;
        ir_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_instr_q <= NOP_INSTR;
      ir_pc4_q   <= 32'h0;
      ir_valid_q <= 1'b0;
    end else begin
      ir_instr_q <= ir_instr_d;
      ir_pc4_q   <= ir_pc4_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign instr_d    = ir_instr_q;
  assign pc_plus4_d = ir_pc4_q;
  assign valid_d    = ir_valid_q;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch plus IF/ID register. Owns the PC, keeps at most one
//   instruction-memory request outstanding, applies decode redirects and
//   hazard stalls.
//   Build option: FETCH_PERF_EN adds perf_fetch_cnt / perf_bubble_cnt.
//   clk, rst_n       clock, synchronous active-low reset
//   stall_d          hold IF/ID and PC
//   redirect_valid   taken branch/jump from decode (beats stall_d)
//   redirect_pc      redirect target, low two bits ignored
//   imem             instruction memory channel (master side)
//   instr_d          IF/ID instruction, NOP when invalid
//   pc_plus4_d       IF/ID pc+4
//   valid_d          IF/ID holds a real instruction
//   perf_fetch_cnt   (FETCH_PERF_EN) instructions loaded into IF/ID
//   perf_bubble_cnt  (FETCH_PERF_EN) cycles IF/ID loaded a bubble
//
//   state  | meaning
//   S_REQ  | request for pc presented, waiting for req_ready
//   S_WAIT | request accepted, waiting for rsp_valid
//   S_HOLD | word received during stall, parked in hold register
// ---------------------------------------------------------------------------
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_d,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  fetch_stage_if.master       imem,
  output logic [31:0]         instr_d,
  output logic [31:0]         pc_plus4_d,
  output logic                valid_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_bubble_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         discard_q, discard_d;
  logic [31:0]  hold_q, hold_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_tgt;
  logic         deliver;
  logic [31:0]  deliver_instr;

  assign pc_plus4     = pc_q + 32'd4;
  assign redirect_tgt = word_align(redirect_pc);

  // The unaccepted request simply follows pc, so a redirect in S_REQ retargets
  // it on the next cycle without extra state.
  assign imem.req_valid = rst_n && (state_q == S_REQ);
  assign imem.req_addr  = pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    discard_d     = discard_q;
    hold_d        = hold_q;
    deliver       = 1'b0;
    deliver_instr = NOP_INSTR;

    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          // A request accepted in the redirect cycle is for the stale pc.
          if (imem.req_ready) begin
            state_d   = S_WAIT;
            discard_d = 1'b1;
          end
        end else if (imem.req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          if (imem.rsp_valid) begin
            state_d   = S_REQ;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem.rsp_valid) begin
          if (discard_q) begin
            state_d   = S_REQ;
            discard_d = 1'b0;
          end else if (!stall_d) begin
            deliver       = 1'b1;
            deliver_instr = imem.rsp_data;
            pc_d          = pc_plus4;
            state_d       = S_REQ;
          end else begin
            hold_d  = imem.rsp_data;
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = S_REQ;
        end else if (!stall_d) begin
          deliver       = 1'b1;
          deliver_instr = hold_q;
          pc_d          = pc_plus4;
          state_d       = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      hold_q    <= NOP_INSTR;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      hold_q    <= hold_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (redirect_valid),
    .stall       (stall_d),
    .load        (deliver),
    .instr_in    (deliver_instr),
    .pc_plus4_in (pc_plus4),
    .instr_d     (instr_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        bubble_load;

  // Mirrors the IF/ID priority: a flush or an unstalled empty cycle is a bubble.
  assign bubble_load = redirect_valid || (!stall_d && !deliver);

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (deliver)     fetch_cnt_d  = fetch_cnt_q + 32'd1;
    if (bubble_load) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall_d;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d, pc_plus4_d;
  logic        valid_d;
  logic [31:0] instr_d2, pc_plus4_d2;
  logic        valid_d2;
`ifdef FETCH_PERF_EN
  logic [31:0] pf_f, pf_b, pf_f2, pf_b2;
`endif

  int errors = 0;
  int checks = 0;

  fetch_stage_if imem ();
  fetch_stage_if imem2 ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall_d(stall_d),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem(imem.master),
    .instr_d(instr_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(pf_f), .perf_bubble_cnt(pf_b)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall_d(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem(imem2.master),
    .instr_d(instr_d2), .pc_plus4_d(pc_plus4_d2), .valid_d(valid_d2)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(pf_f2), .perf_bubble_cnt(pf_b2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'h2400_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_pc4_q[$];

  task automatic exp_fetch(input logic [31:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic exp_load(input logic [31:0] a);
    exp_instr_q.push_back(imem_word(a));
    exp_pc4_q.push_back(a + 32'd4);
  endtask

  // ---------------- memory model for dut ----------------
  int          grants = 0;
  int          mem_lat = 1;
  logic        m_acc, m_pend;
  logic [31:0] m_addr, m_paddr;
  int          m_cnt;

  task automatic grant(input int n);
    grants = n;
    imem.req_ready = (n > 0);
  endtask

  initial begin
    m_pend = 1'b0;
    imem.req_ready = 1'b0;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    m_acc  = imem.req_valid && imem.req_ready;
    m_addr = imem.req_addr;
    #1;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = 32'hDEAD_BEEF;
    if (m_acc) begin
      m_pend  = 1'b1;
      m_paddr = m_addr;
      m_cnt   = mem_lat;
      grants--;
    end
    if (m_pend) begin
      if (m_cnt <= 1) begin
        imem.rsp_valid = 1'b1;
        imem.rsp_data  = imem_word(m_paddr);
        m_pend = 1'b0;
      end else begin
        m_cnt--;
      end
    end
    imem.req_ready = (grants > 0);
  end

  // ---------------- monitors for dut ----------------
  always @(posedge clk) begin
    if (rst_n && imem.req_valid && imem.req_ready) begin
      if (exp_addr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL req_addr: unexpected request got %h expected none", imem.req_addr);
      end else begin
        chk("req_addr", imem.req_addr, exp_addr_q.pop_front());
      end
    end
  end

  logic stall_e, rst_e;
  always @(posedge clk) begin
    stall_e = stall_d;
    rst_e   = rst_n;
    #1;
    if (rst_e && !stall_e && valid_d) begin
      if (exp_instr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ifid_load: unexpected instr got %h expected none", instr_d);
      end else begin
        chk("ifid_instr", instr_d, exp_instr_q.pop_front());
        chk("ifid_pc4", pc_plus4_d, exp_pc4_q.pop_front());
      end
    end
  end

  // ---------------- memory + recorder for dut2 ----------------
  logic        a2_acc;
  logic [31:0] a2_addr;
  logic [31:0] d2_addr [2];
  int          d2_nacc = 0;
  logic        d2_seen = 1'b0;
  logic [31:0] d2_instr, d2_pc4;

  initial begin
    imem2.req_ready = 1'b1;
    imem2.rsp_valid = 1'b0;
    imem2.rsp_data  = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    a2_acc  = imem2.req_valid && imem2.req_ready;
    a2_addr = imem2.req_addr;
    if (rst_n && a2_acc && d2_nacc < 2) begin
      d2_addr[d2_nacc] = a2_addr;
      d2_nacc++;
    end
    #1;
    imem2.rsp_valid = a2_acc;
    imem2.rsp_data  = imem_word(a2_addr);
    if (valid_d2 && !d2_seen) begin
      d2_seen  = 1'b1;
      d2_instr = instr_d2;
      d2_pc4   = pc_plus4_d2;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    stall_d = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    cyc(3);
    chk("rst_req_valid", {31'b0, imem.req_valid}, 32'd0);
    chk("rst_valid_d", {31'b0, valid_d}, 32'd0);
    chk("rst_instr_d", instr_d, 32'h0);
    chk("rst_pc4_d", pc_plus4_d, 32'h0);

    // 1: straight-line fetch, 1-cycle memory
    exp_fetch(32'h0); exp_fetch(32'h4); exp_fetch(32'h8);
    exp_load(32'h0);  exp_load(32'h4);  exp_load(32'h8);
    grant(3);
    rst_n = 1'b1;
    cyc(2);
    chk("s1_valid_pulse", {31'b0, valid_d}, 32'd1);
    chk("s1_pc4_first", pc_plus4_d, 32'h4);
    cyc(1);
    chk("s1_bubble", {31'b0, valid_d}, 32'd0);
    cyc(5);

    // RESET_PC = FFFF_FFFC instance
    if (!d2_seen) begin
      checks++; errors++;
      $display("FAIL wrap_seen: got no load expected one");
    end else begin
      chk("wrap_pc4", d2_pc4, 32'h0);
      chk("wrap_instr", d2_instr, imem_word(32'hFFFF_FFFC));
    end
    chk("wrap_addr0", d2_addr[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", d2_addr[1], 32'h0);

    // 2: stall across the response, word held then released
    exp_fetch(32'hC); exp_fetch(32'h10);
    exp_load(32'hC);  exp_load(32'h10);
    grant(2);
    cyc(2);
    stall_d = 1'b1;
    cyc(2);
    chk("s2_hold_valid", {31'b0, valid_d}, 32'd1);
    chk("s2_hold_instr", instr_d, imem_word(32'hC));
    chk("s2_hold_pc4", pc_plus4_d, 32'h10);
    cyc(1);
    chk("s2_hold_instr2", instr_d, imem_word(32'hC));
    stall_d = 1'b0;
    cyc(1);
    chk("s2_release_instr", instr_d, imem_word(32'h10));
    chk("s2_release_valid", {31'b0, valid_d}, 32'd1);
    cyc(3);

    // 3: redirect while waiting on a 2-cycle response
    mem_lat = 2;
    exp_fetch(32'h14);
    grant(1);
    cyc(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0041;
    cyc(1);
    redirect_valid = 1'b0;
    chk("s3_flush_valid", {31'b0, valid_d}, 32'd0);
    chk("s3_flush_instr", instr_d, 32'h0);
    chk("s3_wait_noreq", {31'b0, imem.req_valid}, 32'd0);
    cyc(1);
    chk("s3_req_valid", {31'b0, imem.req_valid}, 32'd1);
    chk("s3_req_addr", imem.req_addr, 32'h40);
    chk("s3_valid_d", {31'b0, valid_d}, 32'd0);
    mem_lat = 1;
    exp_fetch(32'h40); exp_load(32'h40);
    grant(1);
    cyc(4);

    // 4: redirect + stall together in S_HOLD
    exp_fetch(32'h44); exp_fetch(32'h48);
    exp_load(32'h44);
    grant(2);
    cyc(2);
    stall_d = 1'b1;
    cyc(2);
    chk("s4_held_valid", {31'b0, valid_d}, 32'd1);
    chk("s4_held_instr", instr_d, imem_word(32'h44));
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    cyc(1);
    redirect_valid = 1'b0;
    stall_d = 1'b0;
    chk("s4_flush_valid", {31'b0, valid_d}, 32'd0);
    chk("s4_flush_instr", instr_d, 32'h0);
    chk("s4_req_valid", {31'b0, imem.req_valid}, 32'd1);
    chk("s4_req_addr", imem.req_addr, 32'h100);
    exp_fetch(32'h100); exp_load(32'h100);
    grant(1);
    cyc(4);

    // 5: reset in the middle of S_WAIT, late response ignored
    mem_lat = 4;
    exp_fetch(32'h104);
    grant(1);
    cyc(2);
    rst_n = 1'b0;
    cyc(1);
    chk("s5_rst_req_valid", {31'b0, imem.req_valid}, 32'd0);
    chk("s5_rst_valid_d", {31'b0, valid_d}, 32'd0);
    chk("s5_rst_instr", instr_d, 32'h0);
    chk("s5_rst_pc4", pc_plus4_d, 32'h0);
    rst_n = 1'b1;
    cyc(2);
    chk("s5_req_valid", {31'b0, imem.req_valid}, 32'd1);
    chk("s5_req_addr", imem.req_addr, 32'h0);
    chk("s5_late_ignored", {31'b0, valid_d}, 32'd0);
    mem_lat = 1;
    exp_fetch(32'h0); exp_load(32'h0);
    grant(1);
    cyc(4);

    chk("addr_queue_empty", exp_addr_q.size(), 32'd0);
    chk("load_queue_empty", exp_instr_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
